// File: rtl/cache_pkg.sv
// cache_pkg: shared types, widths and helpers for the page cache controller.
package cache_pkg;
    localparam int ADDR_W = 24;
    // Tag field sized for the smallest page (PAGE_BITS = 8); larger pages leave upper bits zero.
    localparam int PAGE_BITS_MIN = 8;
    localparam int TAG_MAX = ADDR_W - PAGE_BITS_MIN;
    typedef enum logic [1:0] {IDLE, LOOKUP, MISS} state_t;
    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
    } page_entry_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/cache_lru.sv
// cache_lru: age-based LRU tracker; ages stay a permutation of 0..NUM_PAGES-1.
module cache_lru import cache_pkg::*; #(
    parameter int NUM_PAGES = 4,
    localparam int PW = clog2(NUM_PAGES)
) (
    input  logic          fpga,
    input  logic          rst,
    input  logic          touch,
    input  logic [PW-1:0] touch_idx,
    output logic [PW-1:0] victim
);
    logic [PW-1:0] age [NUM_PAGES];

    always_ff @(posedge fpga or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PAGES; i++) age[i] <= PW'(i);
        end else if (touch) begin
            for (int i = 0; i < NUM_PAGES; i++)
                age[i] <= (PW'(i) == touch_idx) ? '0 :
                          (age[i] < age[touch_idx]) ? age[i] + 1'b1 : age[i];
        end
    end

    always_comb begin
        victim = '0;
        for (int i = 0; i < NUM_PAGES; i++)
            if (age[i] == PW'(NUM_PAGES - 1)) victim = PW'(i);
    end
endmodule

// File: rtl/cache_page_ctrl.sv
// cache_page_ctrl: 65C816 bus snooper with fully-associative LRU page table and fill requests.
// Optional hit/miss statistics counters are enabled by defining CACHE_PAGE_STATS_EN.
module cache_page_ctrl import cache_pkg::*; #(
    parameter int NUM_PAGES = 4,
    parameter int PAGE_BITS = 16,
    parameter int SYNC_STAGES = 2,
    localparam int PW = clog2(NUM_PAGES)
) (
    input  logic              fpga,
    input  logic              rst,
    input  logic [15:0]       a,
    input  logic [7:0]        d,
    input  logic              phi2,
    output logic              hit,
    output logic [PW-1:0]     hit_page,
    output logic              miss_req,
    output logic [ADDR_W-1:0] miss_addr,
    output logic [PW-1:0]     miss_page,
    input  logic              miss_ack,
    output logic              fill_done,
    output logic              overrun
`ifdef CACHE_PAGE_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    logic [SYNC_STAGES-1:0] phi2_sync;
    logic [15:0]            a_sync [SYNC_STAGES];
    logic [7:0]             d_sync [SYNC_STAGES];
    logic                   phi2_prev;
    logic [15:0]            a_prev;
    logic [7:0]             d_prev;
    logic [ADDR_W-1:0]      addr_q;
    logic                   phi2_rise;
    state_t                 state, state_n;
    page_entry_t            tbl [NUM_PAGES];
    logic [TAG_MAX-1:0]     tag_q;
    logic                   hit_any, inv_any;
    logic [PW-1:0]          hit_idx, inv_idx, lru_victim, victim;
    logic                   hit_n, fill_n, ovr_n, touch;
    logic [PW-1:0]          page_n, touch_idx;

    // Bus bytes are taken one stage behind the phi2 edge so the bank is the last phi2-low value.
    always_ff @(posedge fpga or posedge rst) begin
        if (rst) begin
            phi2_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sync[i] <= '0;
                d_sync[i] <= '0;
            end
            phi2_prev <= 1'b0;
            a_prev    <= '0;
            d_prev    <= '0;
            addr_q    <= '0;
        end else begin
            phi2_sync <= {phi2_sync[SYNC_STAGES-2:0], phi2};
            a_sync[0] <= a;
            d_sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i] <= a_sync[i-1];
                d_sync[i] <= d_sync[i-1];
            end
            phi2_prev <= phi2_sync[SYNC_STAGES-1];
            a_prev    <= a_sync[SYNC_STAGES-1];
            d_prev    <= d_sync[SYNC_STAGES-1];
            if (phi2_rise && state == IDLE) addr_q <= {d_prev, a_prev};
        end
    end

    assign phi2_rise = phi2_sync[SYNC_STAGES-1] & ~phi2_prev;
    assign tag_q     = TAG_MAX'(addr_q >> PAGE_BITS);

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        for (int i = NUM_PAGES - 1; i >= 0; i--) begin
            if (tbl[i].valid && tbl[i].tag == tag_q) begin
                hit_any = 1'b1;
                hit_idx = PW'(i);
            end
            if (!tbl[i].valid) begin
                inv_any = 1'b1;
                inv_idx = PW'(i);
            end
        end
    end

    assign victim = inv_any ? inv_idx : lru_victim;

    cache_lru #(.NUM_PAGES(NUM_PAGES)) u_lru (
        .fpga(fpga), .rst(rst), .touch(touch), .touch_idx(touch_idx), .victim(lru_victim)
    );

    always_comb begin
        state_n   = state;
        hit_n     = 1'b0;
        fill_n    = 1'b0;
        ovr_n     = phi2_rise && state != IDLE;
        page_n    = hit_page;
        touch     = 1'b0;
        touch_idx = hit_idx;
        case (state)
            IDLE:    state_n = phi2_rise ? LOOKUP : IDLE;
            LOOKUP: begin
                state_n = hit_any ? IDLE : MISS;
                hit_n   = hit_any;
                touch   = hit_any;
                page_n  = hit_any ? hit_idx : hit_page;
            end
            MISS: begin
                state_n   = miss_ack ? IDLE : MISS;
                fill_n    = miss_ack;
                touch     = miss_ack;
                touch_idx = miss_page;
                page_n    = miss_ack ? miss_page : hit_page;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge fpga or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hit       <= 1'b0;
            hit_page  <= '0;
            fill_done <= 1'b0;
            overrun   <= 1'b0;
            miss_addr <= '0;
            miss_page <= '0;
            for (int i = 0; i < NUM_PAGES; i++) tbl[i] <= '0;
        end else begin
            state     <= state_n;
            hit       <= hit_n;
            hit_page  <= page_n;
            fill_done <= fill_n;
            overrun   <= ovr_n;
            if (state == LOOKUP && !hit_any) begin
                miss_addr <= (addr_q >> PAGE_BITS) << PAGE_BITS;
                miss_page <= victim;
            end
            if (fill_n) tbl[miss_page] <= '{valid: 1'b1, tag: tag_q};
        end
    end

    assign miss_req = state == MISS;

`ifdef CACHE_PAGE_STATS_EN
    always_ff @(posedge fpga or posedge rst) begin
        if (rst || stats_clr) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_n && !(&hit_count)) hit_count <= hit_count + 1'b1;
            if (state == LOOKUP && !hit_any && !(&miss_count)) miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_page_ctrl.sv
// tb_cache_page_ctrl: scoreboard bench; main process queues expected events, monitor pops them.
module tb_cache_page_ctrl;
    logic        fpga = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0;
    logic [7:0]  d = '0;
    logic        phi2 = 1'b0;
    logic        miss_ack = 1'b0;
    logic        hit, miss_req, fill_done, overrun;
    logic [1:0]  hit_page, miss_page;
    logic [23:0] miss_addr;
`ifdef CACHE_PAGE_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] hit_count, miss_count;
`endif

    cache_page_ctrl #(.NUM_PAGES(4), .PAGE_BITS(16), .SYNC_STAGES(2)) dut (
        .fpga(fpga), .rst(rst), .a(a), .d(d), .phi2(phi2),
        .hit(hit), .hit_page(hit_page), .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_page(miss_page), .miss_ack(miss_ack), .fill_done(fill_done), .overrun(overrun)
`ifdef CACHE_PAGE_STATS_EN
        , .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 fpga = ~fpga;

    typedef struct {
        int          kind;
        int          page;
        logic [23:0] addr;
    } exp_t;
    localparam int K_HIT = 0, K_MISS = 1, K_FILL = 2, K_OVR = 3;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    logic req_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic pop(input int kind, input int page, input logic [23:0] addr);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event got=kind%0d exp=none", kind);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_page", page, e.page);
            if (e.kind == K_MISS) chk("miss_addr", addr, e.addr);
        end
    endtask

    always @(negedge fpga) begin
        if (hit) pop(K_HIT, int'(hit_page), 24'h0);
        if (miss_req && !req_d) pop(K_MISS, int'(miss_page), miss_addr);
        if (overrun) pop(K_OVR, 0, 24'h0);
        if (fill_done) pop(K_FILL, int'(hit_page), 24'h0);
        req_d = miss_req;
    end

    task automatic push(input int kind, input int page, input logic [23:0] addr);
        q.push_back(exp_t'{kind, page, addr});
    endtask

    // Bank is driven while phi2 low and replaced by a data byte at the same instant phi2 rises.
    task automatic access(input logic [7:0] bank, input logic [15:0] addr);
        d = bank;
        a = addr;
        repeat (6) @(negedge fpga);
        phi2 = 1'b1;
        d = 8'h55;
        repeat (6) @(negedge fpga);
        phi2 = 1'b0;
        repeat (6) @(negedge fpga);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!miss_req && n < 100) begin
            @(negedge fpga);
            n++;
        end
        if (!miss_req) begin
            checks++;
            failures++;
            $display("FAIL miss_req_timeout got=0 exp=1");
        end
    endtask

    task automatic serve(input int dly);
        wait_req();
        repeat (dly) @(negedge fpga);
        miss_ack = 1'b1;
        @(negedge fpga);
        miss_ack = 1'b0;
        repeat (4) @(negedge fpga);
    endtask

    initial begin
        repeat (3) @(negedge fpga);
        chk("reset_outputs", {hit, fill_done, overrun, miss_req, hit_page, miss_page, miss_addr}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge fpga);
        for (int b = 0; b < 4; b++) begin
            push(K_MISS, b, 24'(b) << 16);
            push(K_FILL, b, 24'h0);
            access(8'(b), 16'h0000);
            serve(3);
        end
        push(K_HIT, 0, 24'h0);
        access(8'h00, 16'h1234);
        repeat (4) @(negedge fpga);
        push(K_MISS, 1, 24'h040000);
        access(8'h04, 16'h0000);
        wait_req();
        push(K_OVR, 0, 24'h0);
        push(K_OVR, 0, 24'h0);
        access(8'h07, 16'hbeef);
        access(8'h08, 16'h0001);
        chk("miss_req_held", {31'h0, miss_req}, 32'h1);
        chk("miss_addr_stable", {8'h0, miss_addr}, 32'h040000);
        chk("miss_page_stable", {30'h0, miss_page}, 32'h1);
        push(K_FILL, 1, 24'h0);
        serve(3);
        push(K_MISS, 2, 24'h050000);
        access(8'h05, 16'h0000);
        wait_req();
`ifdef CACHE_PAGE_STATS_EN
        chk("hit_count", hit_count, 32'd1);
        chk("miss_count", miss_count, 32'd6);
        stats_clr = 1'b1;
        @(negedge fpga);
        stats_clr = 1'b0;
        chk("hit_count_clr", hit_count, 32'd0);
        chk("miss_count_clr", miss_count, 32'd0);
`endif
        rst = 1'b1;
        #1;
        chk("reset_midfill", {hit, fill_done, overrun, miss_req, hit_page, miss_page, miss_addr}, 32'h0);
        repeat (2) @(negedge fpga);
        rst = 1'b0;
        @(negedge fpga);
        miss_ack = 1'b1;
        @(negedge fpga);
        miss_ack = 1'b0;
        repeat (5) @(negedge fpga);
        chk("late_ack_ignored", {30'h0, miss_req, fill_done}, 32'h0);
        push(K_MISS, 0, 24'h000000);
        push(K_FILL, 0, 24'h0);
        access(8'h00, 16'h0000);
        serve(3);
        repeat (5) @(negedge fpga);
        chk("queue_empty", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_page_ctrl.md
Name: cache_page_ctrl

Overview:
- Parametrised successor of the single-configuration 65C816 page cache.
- Snoops the CPU bus in the fpga clock domain and rebuilds the 24-bit address: the bank byte sits on d while phi2 is low, and a carries the low 16 bits.
- Looks the address up in a fully-associative page table with LRU replacement and reports hit/page, or raises a fill request to the backing memory engine.
- Sits between the CPU bus pins and the SDRAM/flash fill engine.

Parameters:
- NUM_PAGES, 4, number of cache pages (power of two, 2..16).
- PAGE_BITS, 16, log2 of page size in bytes; tag = addr[23:PAGE_BITS] (8..20).
- SYNC_STAGES, 2, phi2 synchroniser depth (≥2).

Ports:
- fpga  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- a  in  16  CPU address bus.
- d  in  8  CPU data bus; carries the bank byte while phi2 low.
- phi2  in  1  CPU phase-2 clock, asynchronous to fpga.
- hit  out  1  one-cycle pulse: lookup hit.
- hit_page  out  clog2(NUM_PAGES)  page index for hit or completed fill; valid with hit/fill_done.
- miss_req  out  1  level; fill request, held until miss_ack.
- miss_addr  out  24  page-aligned address of the request (low PAGE_BITS = 0).
- miss_page  out  clog2(NUM_PAGES)  victim page receiving the fill.
- miss_ack  in  1  fill engine done; sampled only while miss_req = 1.
- fill_done  out  1  one-cycle pulse after the tag is installed.
- overrun  out  1  one-cycle pulse: a phi2 cycle was dropped while busy.

Behaviour:
- Reset: all outputs 0; all valid bits 0; LRU ages set to index (page i age = i); FSM IDLE. Reset mid-fill drops miss_req immediately; a late miss_ack is ignored.
- Capture:
  - phi2, a and d each pass through SYNC_STAGES flops.
  - A rising edge on synchronised phi2 latches addr = {d_s, a_s} from the same pipeline stage, so the bank sampled is the last value seen while phi2 was low.
- FSM IDLE → LOOKUP on capture.
- LOOKUP (1 cycle): compare tag against all valid entries.
  - Hit: pulse hit, drive hit_page, update LRU, return to IDLE. Latency = 1 fpga cycle after the edge-detect cycle.
  - Miss: choose victim, go to MISS.
- Victim selection: lowest-index invalid page; otherwise the page with age = NUM_PAGES-1.
- MISS:
  - miss_req = 1; miss_addr and miss_page are stable until ack.
  - On miss_ack: write tag, set valid, update LRU for victim, pulse fill_done with hit_page = victim, go to IDLE. miss_req drops the cycle after ack is sampled.
- LRU update on access to page p with old age k: every page with age < k increments, p → 0. Ages always form a permutation of 0..NUM_PAGES-1.
- A phi2 edge arriving in LOOKUP or MISS is not queued: pulse overrun, discard it.
- Simultaneous phi2 edge and miss_ack: ack processed, edge flagged as overrun.
- A miss_ack with miss_req = 0 has no effect.
- Duplicate tags are never installed, because a fill only follows a lookup miss.

Optional Feature:
- Macro CACHE_PAGE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], plus input stats_clr.
  - Counters increment on hit and on entry to MISS, saturate at all-ones, and clear on rst or on stats_clr. stats_clr wins over a same-cycle increment.
- Undefined: ports and counters absent; other behaviour identical.

Decomposition:
- Package cache_pkg:
  - ADDR_W = 24.
  - typedef state_t {IDLE, LOOKUP, MISS}.
  - function clog2.
  - typedef page_entry_t {valid, tag}, with the tag width derived from PAGE_BITS.
- Sub-module cache_lru (NUM_PAGES): age array, touch strobe + index in, victim index out, reset-to-index ages.
- The synchroniser stays inline.

Test Plan (NUM_PAGES=4, PAGE_BITS=16):
- Reset, then banks 00,01,02,03 on successive phi2 cycles, each acked after 3 cycles → 4 misses, miss_page 0,1,2,3, miss_addr 000000/010000/020000/030000, fill_done each.
- Then bank 00 addr 1234 → hit=1, hit_page=0, no miss_req.
- Then bank 04 → miss, victim page 1 (LRU after access order 1,2,3,0), miss_addr 040000.
- Hold miss_ack low while phi2 toggles twice → overrun pulses twice, miss_req held, miss_addr unchanged; ack → fill_done.
- Assert rst while miss_req=1, then pulse miss_ack → all outputs 0, no fill_done, next access to bank 00 misses into page 0.
- With CACHE_PAGE_STATS_EN: the above sequence gives hit_count=1, miss_count=6; pulsing stats_clr zeroes both.
